// File: rtl/axil_arb_pkg.sv
// Shared types and helpers for the AXI-Lite write arbiter.
package axil_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int RESP_OKAY   = 0;
  localparam int RESP_SLVERR = 2;

  // Next requester index with wrap-around at n.
  function automatic logic [31:0] wrap_inc(input logic [31:0] idx, input int n);
    return (idx + 32'd1 >= 32'(n)) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/axil_rr_arbiter.sv
// Requester selection: round-robin from last_grant+1, or lowest-index-wins
// when AXIL_ARB_FIXED_PRIO_EN is defined.
module axil_rr_arbiter
  import axil_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               found
);

`ifdef AXIL_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_grant;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (en && req[k]) begin
        grant = IDX_W'(k);
        found = 1'b1;
      end
    end
  end
`else
  logic [31:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = wrap_inc(32'(last_grant), NUM_REQ);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (en && !found && req[idx[IDX_W-1:0]]) begin
        grant = idx[IDX_W-1:0];
        found = 1'b1;
      end
      idx = wrap_inc(idx, NUM_REQ);
    end
  end
`endif

endmodule

// File: rtl/axil_write_arbiter.sv
// Shares one AXI-Lite write port among NUM_REQ masters, one transaction at a time.
// Define AXIL_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module axil_write_arbiter
  import axil_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int NUM_REQ    = 2
) (
  input  logic                                 axi_aclk,
  input  logic                                 axi_areset,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic [NUM_REQ-1:0]                   s_axi_awvalid,
  output logic [NUM_REQ-1:0]                   s_axi_awready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]        s_axi_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8+1)-1:0]  s_axi_wstrb,
  input  logic [NUM_REQ-1:0]                   s_axi_wvalid,
  output logic [NUM_REQ-1:0]                   s_axi_wready,
  output logic [NUM_REQ*RESP_WIDTH-1:0]        s_axi_bresp,
  output logic [NUM_REQ-1:0]                   s_axi_bvalid,
  input  logic [NUM_REQ-1:0]                   s_axi_bready,
  output logic [ADDR_WIDTH-1:0]                m_axi_awaddr,
  output logic                                 m_axi_awvalid,
  input  logic                                 m_axi_awready,
  output logic [DATA_WIDTH-1:0]                m_axi_wdata,
  output logic [DATA_WIDTH/8:0]                m_axi_wstrb,
  output logic                                 m_axi_wvalid,
  input  logic                                 m_axi_wready,
  input  logic [RESP_WIDTH-1:0]                m_axi_bresp,
  input  logic                                 m_axi_bvalid,
  output logic                                 m_axi_bready,
  output logic [$clog2(NUM_REQ)-1:0]           grant_id,
  output logic                                 busy
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH/8 + 1;

  arb_state_t       state;
  logic [IDX_W-1:0] last_grant;
  logic             aw_done, w_done;
  logic             in_xfer, in_resp;
  logic             aw_hs, w_hs;
  logic [IDX_W-1:0] arb_grant;
  logic             arb_found;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] awaddr_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_a;
  logic [NUM_REQ-1:0][STRB_W-1:0]     wstrb_a;
  logic [NUM_REQ-1:0][RESP_WIDTH-1:0] bresp_a;

  assign awaddr_a    = s_axi_awaddr;
  assign wdata_a     = s_axi_wdata;
  assign wstrb_a     = s_axi_wstrb;
  assign s_axi_bresp = bresp_a;

  assign in_xfer = (state == XFER);
  assign in_resp = (state == RESP);

  axil_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (s_axi_awvalid),
    .en         (state == IDLE),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .found      (arb_found)
  );

  // Downstream side: everything is muxed from the owner and zeroed outside its phase.
  assign m_axi_awvalid = in_xfer & s_axi_awvalid[grant_id] & ~aw_done;
  assign m_axi_wvalid  = in_xfer & s_axi_wvalid[grant_id] & ~w_done;
  assign aw_hs         = m_axi_awvalid & m_axi_awready;
  assign w_hs          = m_axi_wvalid & m_axi_wready;
  assign m_axi_awaddr  = in_xfer ? awaddr_a[grant_id] : '0;
  assign m_axi_wdata   = in_xfer ? wdata_a[grant_id]  : '0;
  assign m_axi_wstrb   = in_xfer ? wstrb_a[grant_id]  : '0;
  assign m_axi_bready  = in_resp & s_axi_bready[grant_id];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    logic sel;
    assign sel              = (grant_id == IDX_W'(i));
    assign s_axi_awready[i] = in_xfer & sel & m_axi_awready & ~aw_done;
    assign s_axi_wready[i]  = in_xfer & sel & m_axi_wready & ~w_done;
    assign s_axi_bvalid[i]  = in_resp & sel & m_axi_bvalid;
    assign bresp_a[i]       = (in_resp & sel) ? m_axi_bresp : '0;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state      <= IDLE;
      grant_id   <= '0;
      busy       <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant_id <= arb_grant;
            busy     <= 1'b1;
            state    <= XFER;
          end
        end
        XFER: begin
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= RESP;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        RESP: begin
          if (m_axi_bvalid && s_axi_bready[grant_id]) begin
            last_grant <= grant_id;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axil_write_arbiter.md
Name: axil_write_arbiter

Overview:
- Shares the single write port of the bus block (s0 write address, write data and write response channels) between NUM_REQ upstream AXI-Lite masters.
- Handles one write transaction at a time: arbitrate, forward AW and W, route B back to the granted requester, release.
- Round-robin fairness by default. Sits directly upstream of the bus s0 write channels; the read path is not touched.

Parameters:
- DATA_WIDTH, 32, data width; matches the bus.
- ADDR_WIDTH, 8, address width; matches the bus.
- RESP_WIDTH, 3, response width; matches the bus.
- NUM_REQ, 2, number of upstream requesters; legal range 2..8.

Ports:
- axi_aclk  in  1  single clock for all channels
- axi_areset  in  1  synchronous, active-high reset
- s_axi_awaddr  in  NUM_REQ*ADDR_WIDTH  packed per requester; slice i belongs to requester i
- s_axi_awvalid  in  NUM_REQ  per-requester AW valid
- s_axi_awready  out  NUM_REQ  per-requester AW ready
- s_axi_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- s_axi_wstrb  in  NUM_REQ*(DATA_WIDTH/8+1)  packed strobes; same width as the bus wstrb
- s_axi_wvalid  in  NUM_REQ  per-requester W valid
- s_axi_wready  out  NUM_REQ  per-requester W ready
- s_axi_bresp  out  NUM_REQ*RESP_WIDTH  packed write response
- s_axi_bvalid  out  NUM_REQ  per-requester B valid
- s_axi_bready  in  NUM_REQ  per-requester B ready
- m_axi_awaddr / m_axi_awvalid / m_axi_awready  out/out/in  ADDR_WIDTH/1/1  downstream AW channel to the bus s0
- m_axi_wdata / m_axi_wstrb / m_axi_wvalid / m_axi_wready  out/out/out/in  DATA_WIDTH/(DATA_WIDTH/8+1)/1/1  downstream W channel
- m_axi_bresp / m_axi_bvalid / m_axi_bready  in/in/out  RESP_WIDTH/1/1  downstream B channel
- grant_id  out  $clog2(NUM_REQ)  index of the current owner; valid while busy
- busy  out  1  high from grant until B completes

Behaviour:
- Reset (synchronous, axi_areset=1 at the clock edge):
  - State = IDLE; grant_id = 0; busy = 0; aw_done = w_done = 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
  - All ready/valid outputs are 0. Data outputs are 0.
  - Reset mid-transaction abandons the transaction with no upstream response. All outputs are 0 in the cycle after the reset edge.
- FSM: IDLE -> XFER -> RESP -> IDLE.
- IDLE:
  - All s_* ready/valid outputs and all m_* valid/ready outputs are 0.
  - If any s_axi_awvalid bit is set, pick the first set bit scanning from last_grant+1 with wrap-around.
  - Register that index into grant_id, set busy, go to XFER. Arbitration latency is 1 cycle; wvalid is not required to win.
- XFER (combinational mux from the granted slice g):
  - m_axi_awvalid = s_axi_awvalid[g] & ~aw_done; s_axi_awready[g] = m_axi_awready & ~aw_done.
  - m_axi_wvalid = s_axi_wvalid[g] & ~w_done; s_axi_wready[g] = m_axi_wready & ~w_done.
  - Address, data and strobe pass through unmodified.
  - aw_done / w_done are set on the respective handshake. AW and W may complete in either order or in the same cycle.
  - When both are done (including same-cycle completion): go to RESP and clear both flags.
- RESP:
  - s_axi_bvalid[g] = m_axi_bvalid; m_axi_bready = s_axi_bready[g]; s_axi_bresp slice g = m_axi_bresp, passed unchanged including error codes.
  - On m_axi_bvalid & s_axi_bready[g]: last_grant = g, busy = 0, go to IDLE.
- Non-granted requesters: ready and bvalid are held at 0. Their bresp slices are 0.
- Requester deasserts awvalid or wvalid after grant: AXI violation. The grant is held until the handshake; no recovery path.
- Back-to-back: at least 1 IDLE cycle between transactions. Minimum transaction is 4 cycles when the downstream answers immediately.
- Single active requester: it wins every arbitration.

Optional Feature:
- Macro: AXIL_ARB_FIXED_PRIO_EN.
- Defined: last_grant is ignored and the lowest index with awvalid set always wins; starvation of higher indices is permitted.
- Undefined: round-robin as specified above.
- All ports and timing are identical in both builds.

Decomposition:
- Package axil_arb_pkg:
  - enum arb_state_t {IDLE, XFER, RESP}.
  - Localparams RESP_OKAY=0, RESP_SLVERR=2.
  - Function for the wrap-around next-index computation.
- Sub-module axil_rr_arbiter: takes the request vector, enable and last_grant, returns grant index and grant-found flag. Contains the AXIL_ARB_FIXED_PRIO_EN switch. The top module instantiates it once.

Test Plan:
- Req0 alone writes addr 0x04 data 0xDEADBEEF strb 0x0F, downstream awready/wready/bvalid immediate, bresp=1 -> m_axi_awaddr=0x04, s_axi_bresp[0]=1, busy low after 4 cycles, grant_id=0.
- Req0 and req1 both assert awvalid from reset, 3 transactions each -> grant order 0,1,0,1,0,1. With AXIL_ARB_FIXED_PRIO_EN the order is 0,0,0,1,1,1.
- Granted req1, W handshake 3 cycles before AW (addr 0x10) -> exactly one AW and one W downstream, no duplicate wvalid after w_done, RESP entered on the AW handshake cycle.
- RESP with m_axi_bvalid=1 but s_axi_bready[1]=0 for 5 cycles -> m_axi_bready=0 and bvalid held, no release; completes on the cycle bready rises.
- axi_areset pulsed for 1 cycle while in XFER with aw_done=1 -> next cycle all outputs 0, busy=0; the next request is granted to requester 0.
- Req1 writes addr 0x14 while req0 idle -> s_axi_awready[0], s_axi_wready[0] and s_axi_bvalid[0] stay 0 throughout.
